fluxo_dados_n: RTL and testbench
================================

Name: fluxo_dados_n

Overview:
Parametrised datapath for the memory-sequence game; successor of the fixed 4-button/16-entry datapath.
- Generalised in button count, sequence depth and timer lengths.
- Adds a writable sequence RAM, so the player appends a new move each round.
- Adds multi-button rejection and a sticky response timeout.
- Driven by the game FSM (unidade de controle) through zera/conta/registra strobes; returns status flags.

Parameters:
N_BOTOES, 4, button/LED count; width of jogada and memory word
DEPTH, 16, max sequence length; ADDR_W = $clog2(DEPTH), min 1
TIMEOUT_CYC, 5000, cycles without any button before timeout (5 s at 1 kHz)
SHOW_CYC, 500, display-timer period in cycles

Ports:
clock  in  1  system clock, all state rising-edge
reset  in  1  asynchronous, active-low; clears all registers/counters (not RAM contents)
botoes  in  N_BOTOES  raw button inputs, already synchronised
zeraE, contaE  in  1  address counter clear/increment
zeraS, contaS  in  1  sequence-length counter clear/increment
zeraR, registraR  in  1  jogada register clear/load
escreveM  in  1  write jogada register into RAM[endereco]
zeraTMR, contaTMR  in  1  display timer clear/enable
fimE, fimS  out  1  counter at DEPTH-1
fimTMR  out  1  display timer at SHOW_CYC-1
jogada_feita  out  1  one-cycle pulse, rising edge of any-button-pressed
jogada_valida  out  1  registered jogada is exactly one-hot
chavesIgualMemoria  out  1  jogada == RAM data
enderecoIgualSequencia, enderecoMenorSequencia  out  1  endereco == / < sequencia
timeout  out  1  sticky timeout flag
leds  out  N_BOTOES  RAM data when contaTMR=1, else 0
db_endereco, db_sequencia  out  ADDR_W  counter values
db_jogada, db_memoria  out  N_BOTOES  register / RAM data
db_tem_jogada  out  1  |botoes

Behaviour:
Reset (reset=0, async) sets every register to 0:
- Both counters, jogada register, edge-detector history, both timers and timeout = 0.
- Hence leds=0, fimE=fimS=0, jogada_feita=0.
- enderecoIgualSequencia=1 while both counters are 0.
- RAM contents are untouched by reset.

Counters (address, sequence): ADDR_W bits.
- Per counter, zera has priority over conta.
- Wrap DEPTH-1 -> 0 on conta.
- fim = (count == DEPTH-1), combinational.

Jogada register:
- zeraR has priority over registraR.
- Loads botoes on registraR.
- jogada_valida = register has exactly one bit set (0 or >=2 bits -> 0).

RAM: DEPTH x N_BOTOES.
- Synchronous write: escreveM=1 stores jogada register at current endereco.
- Synchronous read: db_memoria reflects RAM[endereco] one cycle after endereco changes or after a write to that address (read-after-write returns new data next cycle).

Comparators are combinational on registered values.

Edge detector:
- tem_q <= |botoes each cycle.
- jogada_feita = (|botoes) & ~tem_q, combinational.
- Holding a button gives one pulse only; release-and-press gives a new pulse.

Timeout timer, 0..TIMEOUT_CYC-1:
- Cleared synchronously when zeraE or contaE is 1.
- Counts while |botoes=0 and timeout=0.
- Holds while a button is down.
- Reaching TIMEOUT_CYC-1 sets timeout=1 next cycle.
- timeout stays 1 until zeraE/contaE/reset.
- Simultaneous clear and terminal count: clear wins.

Display timer, 0..SHOW_CYC-1:
- zeraTMR has priority.
- Counts on contaTMR and wraps.
- fimTMR = (count == SHOW_CYC-1).

Optional Feature:
Macro FLUXO_DADOS_N_TIMEOUT_EN.
- Defined: timeout timer present as specified.
- Undefined: timer not instantiated; timeout tied 0; no timer flops synthesised.

Test Plan:
- Reset mid-count: hold contaE 5 cycles, reset=0 -> db_endereco=0, timeout=0, leds=0 immediately (async); RAM word 3 retains prior value after release.
- Wrap: DEPTH=16, pulse contaS 15 times -> db_sequencia=15, fimS=1; one more -> 0, fimS=0. Same zeraS+contaS cycle -> 0.
- Write/read: botoes=4'b0100, registraR, endereco=2, escreveM -> next cycle db_memoria=4'b0100, chavesIgualMemoria=1. botoes=4'b0110 registered -> jogada_valida=0.
- Edge: botoes 0 -> 0001 held 10 cycles -> jogada_feita exactly 1 pulse; release 3 cycles then press -> second pulse.
- Timeout: TIMEOUT_CYC=8, no buttons -> timeout=1 after 8 cycles and sticky; button press 3 cycles midway holds count. contaE clears it. With macro undefined, timeout stays 0.
- Display: SHOW_CYC=4, contaTMR=1 -> fimTMR every 4th cycle; leds=RAM data only while contaTMR=1.

Source files
------------

// File: rtl/fluxo_dados_n.sv
`default_nettype none
// ============================================================================
// Module   : fluxo_dados_n
// Brief    : Parametrised memory-game datapath: address/sequence counters,
//            jogada register, sequence RAM, edge detector and timers.
//            Optional response timeout built only with FLUXO_DADOS_N_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fluxo_dados_n #(
  parameter int N_BOTOES    = 4,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SHOW_CYC    = 500,
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                zeraE,
  input  logic                contaE,
  input  logic                zeraS,
  input  logic                contaS,
  input  logic                zeraR,
  input  logic                registraR,
  input  logic                escreveM,
  input  logic                zeraTMR,
  input  logic                contaTMR,
  output logic                fimE,
  output logic                fimS,
  output logic                fimTMR,
  output logic                jogada_feita,
  output logic                jogada_valida,
  output logic                chavesIgualMemoria,
  output logic                enderecoIgualSequencia,
  output logic                enderecoMenorSequencia,
  output logic                timeout,
  output logic [N_BOTOES-1:0] leds,
  output logic [ADDR_W-1:0]   db_endereco,
  output logic [ADDR_W-1:0]   db_sequencia,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic [N_BOTOES-1:0] db_memoria,
  output logic                db_tem_jogada
);

  localparam int c_SHOW_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam logic [ADDR_W-1:0]   c_ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [c_SHOW_W-1:0] c_SHOW_LAST = c_SHOW_W'(SHOW_CYC - 1);

  logic [ADDR_W-1:0]   r_endereco;
  logic [ADDR_W-1:0]   r_sequencia;
  logic [N_BOTOES-1:0] r_jogada;
  logic [N_BOTOES-1:0] r_mem_q;
  logic [N_BOTOES-1:0] r_mem [DEPTH];
  logic                r_tem_q;
  logic [c_SHOW_W-1:0] r_tmr;
  logic                w_tem_jogada;

  assign w_tem_jogada = |botoes;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_endereco <= '0;
    end else if (zeraE) begin
      r_endereco <= '0;
    end else if (contaE) begin
      r_endereco <= (r_endereco == c_ADDR_LAST) ? '0 : r_endereco + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sequencia <= '0;
    end else if (zeraS) begin
      r_sequencia <= '0;
    end else if (contaS) begin
      r_sequencia <= (r_sequencia == c_ADDR_LAST) ? '0 : r_sequencia + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_jogada <= '0;
    end else if (zeraR) begin
      r_jogada <= '0;
    end else if (registraR) begin
      r_jogada <= botoes;
    end
  end

  // Storage array is intentionally not reset so the sequence survives a reset.
  always_ff @(posedge clock) begin
    if (escreveM) begin
      r_mem[r_endereco] <= r_jogada;
    end
  end

  // Write-first read port: a write shows up on db_memoria on the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem_q <= '0;
    end else if (escreveM) begin
      r_mem_q <= r_jogada;
    end else begin
      r_mem_q <= r_mem[r_endereco];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tem_q <= 1'b0;
    end else begin
      r_tem_q <= w_tem_jogada;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmr <= '0;
    end else if (zeraTMR) begin
      r_tmr <= '0;
    end else if (contaTMR) begin
      r_tmr <= (r_tmr == c_SHOW_LAST) ? '0 : r_tmr + 1'b1;
    end
  end

`ifdef FLUXO_DADOS_N_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout;

  // Counter parks at its terminal value; the sticky flag then freezes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (zeraE || contaE) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_to_cnt == c_TO_LAST) begin
        r_timeout <= 1'b1;
      end else if (!w_tem_jogada && !r_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign fimE                   = (r_endereco == c_ADDR_LAST);
  assign fimS                   = (r_sequencia == c_ADDR_LAST);
  assign fimTMR                 = (r_tmr == c_SHOW_LAST);
  assign jogada_feita           = w_tem_jogada & ~r_tem_q;
  assign jogada_valida          = (r_jogada != '0) &&
                                  ((r_jogada & (r_jogada - N_BOTOES'(1))) == '0);
  assign chavesIgualMemoria     = (r_jogada == r_mem_q);
  assign enderecoIgualSequencia = (r_endereco == r_sequencia);
  assign enderecoMenorSequencia = (r_endereco < r_sequencia);
  assign leds                   = contaTMR ? r_mem_q : '0;
  assign db_endereco            = r_endereco;
  assign db_sequencia           = r_sequencia;
  assign db_jogada              = r_jogada;
  assign db_memoria             = r_mem_q;
  assign db_tem_jogada          = w_tem_jogada;

endmodule
`default_nettype wire

// File: tb/tb_fluxo_dados_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_fluxo_dados_n
// Brief    : Directed self-checking bench for fluxo_dados_n (small timers).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fluxo_dados_n;

  localparam int N_B = 4;
  localparam int AW  = 4;
`ifdef FLUXO_DADOS_N_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N_B-1:0] botoes = '0;
  logic zeraE = 0, contaE = 0, zeraS = 0, contaS = 0, zeraR = 0, registraR = 0;
  logic escreveM = 0, zeraTMR = 0, contaTMR = 0;
  logic fimE, fimS, fimTMR, jogada_feita, jogada_valida, chavesIgualMemoria;
  logic enderecoIgualSequencia, enderecoMenorSequencia, timeout, db_tem_jogada;
  logic [N_B-1:0] leds, db_jogada, db_memoria;
  logic [AW-1:0]  db_endereco, db_sequencia;

  int vectors = 0;
  int errors  = 0;
  int pulses;

  fluxo_dados_n #(
    .N_BOTOES(4), .DEPTH(16), .TIMEOUT_CYC(8), .SHOW_CYC(4)
  ) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .zeraTMR(zeraTMR), .contaTMR(contaTMR),
    .fimE(fimE), .fimS(fimS), .fimTMR(fimTMR),
    .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
    .chavesIgualMemoria(chavesIgualMemoria),
    .enderecoIgualSequencia(enderecoIgualSequencia),
    .enderecoMenorSequencia(enderecoMenorSequencia),
    .timeout(timeout), .leds(leds),
    .db_endereco(db_endereco), .db_sequencia(db_sequencia),
    .db_jogada(db_jogada), .db_memoria(db_memoria),
    .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_endereco", 32'(db_endereco), 0);
    chk("rst_sequencia", 32'(db_sequencia), 0);
    chk("rst_igualseq", 32'(enderecoIgualSequencia), 1);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_fimE", 32'(fimE), 0);
    chk("rst_jogada_feita", 32'(jogada_feita), 0);
    chk("rst_timeout", 32'(timeout), 0);
    tick();
    reset = 1'b1;
    tick();

    // Register a one-hot move and write it at address 2
    botoes = 4'b0100; registraR = 1; tick(); registraR = 0; botoes = '0;
    chk("reg_jogada", 32'(db_jogada), 32'h4);
    chk("reg_valida", 32'(jogada_valida), 1);
    contaE = 1; tick(2); contaE = 0;
    chk("addr_2", 32'(db_endereco), 2);
    chk("addr_menor_seq0", 32'(enderecoMenorSequencia), 0);
    chk("addr_igual_seq0", 32'(enderecoIgualSequencia), 0);
    escreveM = 1; tick(); escreveM = 0; tick();
    chk("ram_rd_w2", 32'(db_memoria), 32'h4);
    chk("ram_igual_w2", 32'(chavesIgualMemoria), 1);

    // Address 3 holds 0010 for the reset-retention check
    contaE = 1; tick(); contaE = 0;
    botoes = 4'b0010; registraR = 1; tick(); registraR = 0; botoes = '0;
    escreveM = 1; tick(); escreveM = 0; tick();
    chk("ram_rd_w3", 32'(db_memoria), 32'h2);

    // Two-bit and zero moves are invalid
    botoes = 4'b0110; registraR = 1; tick(); registraR = 0; botoes = '0;
    chk("inval_2bit", 32'(jogada_valida), 0);
    chk("inval_neq_mem", 32'(chavesIgualMemoria), 0);
    zeraR = 1; registraR = 1; botoes = 4'b1000; tick();
    zeraR = 0; registraR = 0; botoes = '0;
    chk("zeraR_prio", 32'(db_jogada), 0);
    chk("inval_zero", 32'(jogada_valida), 0);

    // Sequence counter wrap
    contaS = 1; tick(15); contaS = 0;
    chk("seq_15", 32'(db_sequencia), 15);
    chk("seq_fimS", 32'(fimS), 1);
    chk("seq_menor", 32'(enderecoMenorSequencia), 1);
    contaS = 1; tick(); contaS = 0;
    chk("seq_wrap", 32'(db_sequencia), 0);
    chk("seq_wrap_fimS", 32'(fimS), 0);
    contaS = 1; tick(3);
    chk("seq_3", 32'(db_sequencia), 3);
    zeraS = 1; tick(); zeraS = 0; contaS = 0;
    chk("seq_zera_prio", 32'(db_sequencia), 0);

    // Address counter terminal and wrap
    zeraE = 1; tick(); zeraE = 0;
    contaE = 1; tick(15); contaE = 0;
    chk("addr_fimE", 32'(fimE), 1);
    contaE = 1; tick(); contaE = 0;
    chk("addr_wrap", 32'(db_endereco), 0);

    // Reset mid-count, while leds are showing RAM data
    contaE = 1; tick(3); contaE = 0; tick();
    contaTMR = 1; #1;
    chk("leds_on_w3", 32'(leds), 32'h2);
    contaE = 1; tick(5);
    #2 reset = 1'b0; #1;
    chk("arst_endereco", 32'(db_endereco), 0);
    chk("arst_timeout", 32'(timeout), 0);
    chk("arst_leds", 32'(leds), 0);
    contaE = 0; contaTMR = 0;
    tick(); reset = 1'b1;
    contaE = 1; tick(3); contaE = 0; tick();
    chk("ram_retained_w3", 32'(db_memoria), 32'h2);

    // Edge detector: held press gives one pulse, re-press gives another
    botoes = 4'b0001; #1;
    pulses = 32'(jogada_feita);
    for (int i = 0; i < 9; i++) begin
      tick();
      pulses += 32'(jogada_feita);
    end
    chk("edge_one_pulse", pulses, 1);
    chk("edge_tem_jogada", 32'(db_tem_jogada), 1);
    botoes = '0; tick(3);
    botoes = 4'b0001; #1;
    chk("edge_repress", 32'(jogada_feita), 1);
    tick();
    chk("edge_repress_end", 32'(jogada_feita), 0);
    botoes = '0; tick();

    // Display timer: period 4, leds gated by contaTMR
    zeraTMR = 1; tick(); zeraTMR = 0;
    contaTMR = 1; #1;
    chk("disp_leds", 32'(leds), 32'h2);
    tick(2);
    chk("disp_fim_c2", 32'(fimTMR), 0);
    tick();
    chk("disp_fim_c3", 32'(fimTMR), 1);
    tick();
    chk("disp_fim_c4", 32'(fimTMR), 0);
    tick(3);
    chk("disp_fim_c7", 32'(fimTMR), 1);
    contaTMR = 0; #1;
    chk("disp_leds_off", 32'(leds), 0);
    tick();
    chk("disp_hold", 32'(fimTMR), 1);

    // Timeout: 8 idle cycles, a 3-cycle press pauses the count
    zeraE = 1; tick(); zeraE = 0;
    tick(3);
    botoes = 4'b1000; tick(3); botoes = '0;
    tick(4);
    chk("to_before", 32'(timeout), 0);
    tick();
    chk("to_set", 32'(timeout), 32'(TO_EN));
    tick(5);
    chk("to_sticky", 32'(timeout), 32'(TO_EN));
    contaE = 1; tick(); contaE = 0;
    chk("to_clear", 32'(timeout), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
